// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multi-cycle control path: opcodes, select codes, FSM states.
// Select codes are shared with the ALU and NPC blocks, so do not renumber them.
package mc_defs;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;

  localparam logic [2:0] NPC_ADD4 = 3'd0;
  localparam logic [2:0] NPC_BEQ  = 3'd1;
  localparam logic [2:0] NPC_JAL  = 3'd2;
  localparam logic [2:0] NPC_REG  = 3'd3;

  localparam logic [2:0] WD_ALU   = 3'd0;
  localparam logic [2:0] WD_MEM   = 3'd1;
  localparam logic [2:0] WD_PC    = 3'd2;
  localparam logic [2:0] WD_LUI   = 3'd3;

  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_RA   = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic jal;
    logic jr;
  } iclass_t;
endpackage

// File: rtl/mc_controller_decode.sv
// Combinational opcode/func decode into a one-hot instruction class plus an illegal flag.
// Zero latency, no flow control.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_func,
  output iclass_t    o_cls,
  output logic       o_illegal
);
  logic w_rtype;

  assign w_rtype = (i_opcode == OP_RTYPE);

  always_comb begin
    o_cls      = '0;
    o_cls.addu = w_rtype && (i_func == FN_ADDU);
    o_cls.subu = w_rtype && (i_func == FN_SUBU);
    o_cls.jr   = w_rtype && (i_func == FN_JR);
    o_cls.ori  = (i_opcode == OP_ORI);
    o_cls.lw   = (i_opcode == OP_LW);
    o_cls.sw   = (i_opcode == OP_SW);
    o_cls.beq  = (i_opcode == OP_BEQ);
    o_cls.lui  = (i_opcode == OP_LUI);
    o_cls.jal  = (i_opcode == OP_JAL);
  end

  // Anything outside the supported set, including the all-zero nop, is illegal.
  assign o_illegal = (o_cls == '0);
endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with memory wait states.
// Enables are combinational from state; memory states last MEM_WAIT+1 cycles.
module mc_controller
  import mc_defs::*;
#(
  parameter int MEM_WAIT     = 0,
  parameter int ILLEGAL_TRAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [2:0] NPC_sel,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [2:0] WD_sel,
  output logic       ExtOp,
  output logic       ALU_s,
  output logic [2:0] ALUOP,
  output logic       MemWrite,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state
);
  localparam int CNT_W = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal;
  iclass_t          w_cls;
  logic             w_illegal;
  logic             w_mem_phase;
  logic             w_done;

  mc_decode u_decode (
    .i_opcode  (opcode),
    .i_func    (func),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_done      = (r_cnt == WAIT_LAST);

  // Counter is zero on entry to FETCH/MEM because it clears whenever an access completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_mem_phase && !w_done) ? r_cnt + CNT_W'(1) : '0;
      if (r_state == S_DECODE && w_illegal)
        r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:  if (w_done) w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_cls.jal || w_cls.jr)
          w_state_nxt = S_FETCH;
        else if (w_illegal)
          w_state_nxt = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
        else
          w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (w_cls.lw || w_cls.sw)
          w_state_nxt = S_MEM;
        else if (w_cls.beq)
          w_state_nxt = S_FETCH;
        else
          w_state_nxt = S_WB;
      end
      S_MEM:    if (w_done) w_state_nxt = w_cls.lw ? S_WB : S_FETCH;
      S_WB:     w_state_nxt = S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    NPC_sel  = NPC_ADD4;
    RegWrite = 1'b0;
    RegDst   = DST_RT;
    WD_sel   = WD_ALU;
    ExtOp    = 1'b0;
    ALU_s    = 1'b0;
    ALUOP    = ALU_ADD;
    MemWrite = 1'b0;
    retire   = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: if (w_done) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        S_DECODE: begin
          if (w_cls.jal) begin
            PCWrite  = 1'b1;
            NPC_sel  = NPC_JAL;
            RegWrite = 1'b1;
            RegDst   = DST_RA;
            WD_sel   = WD_PC;
            retire   = 1'b1;
          end else if (w_cls.jr) begin
            PCWrite = 1'b1;
            NPC_sel = NPC_REG;
            retire  = 1'b1;
          end else if (w_illegal && ILLEGAL_TRAP == 0) begin
            retire = 1'b1;
          end
        end
        S_EXEC: begin
          if (w_cls.subu) begin
            ALUOP = ALU_SUB;
          end else if (w_cls.ori) begin
            ALUOP = ALU_OR;
            ALU_s = 1'b1;
          end else if (w_cls.lw || w_cls.sw) begin
            ALU_s = 1'b1;
            ExtOp = 1'b1;
          end else if (w_cls.beq) begin
            ALUOP   = ALU_SUB;
            ExtOp   = 1'b1;
            NPC_sel = NPC_BEQ;
            PCWrite = zero;
            retire  = 1'b1;
          end
        end
        // The store strobe only fires once the access has fully waited out.
        S_MEM: if (w_done && w_cls.sw) begin
          MemWrite = 1'b1;
          retire   = 1'b1;
        end
        S_WB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          if (w_cls.addu || w_cls.subu) RegDst = DST_RD;
          else if (w_cls.lw)            WD_sel = WD_MEM;
          else if (w_cls.lui)           WD_sel = WD_LUI;
        end
        default: ;
      endcase
    end
  end

  assign illegal = r_illegal;
  assign state   = r_state;
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: three instances (wait 0 / wait 2 with trap / wait 3),
// directed scenarios plus random instruction streams against a per-instruction reference model.
module tb_mc_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic [5:0] opc [3];
  logic [5:0] fnc [3];
  logic       zr  [3];
  logic       irw [3], pcw [3], rw [3], ext [3], alus [3], mw [3], ret [3], ill [3];
  logic [2:0] npc [3], wd [3], aluop [3], st [3];
  logic [1:0] dst [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mc_controller #(
      .MEM_WAIT     (g == 0 ? 0 : (g == 1 ? 2 : 3)),
      .ILLEGAL_TRAP (g == 1 ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .reset    (rst[g]),
      .opcode   (opc[g]),
      .func     (fnc[g]),
      .zero     (zr[g]),
      .IRWrite  (irw[g]),
      .PCWrite  (pcw[g]),
      .NPC_sel  (npc[g]),
      .RegWrite (rw[g]),
      .RegDst   (dst[g]),
      .WD_sel   (wd[g]),
      .ExtOp    (ext[g]),
      .ALU_s    (alus[g]),
      .ALUOP    (aluop[g]),
      .MemWrite (mw[g]),
      .retire   (ret[g]),
      .illegal  (ill[g]),
      .state    (st[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Per-instruction observations gathered by run_instr.
  int o_len, o_irw_n, o_irw_at, o_pcw_n, o_rw_n, o_rw_at, o_mw_n, o_mw_at, o_ret_n;
  logic [1:0] o_dst;
  logic [2:0] o_wd, o_npc_j, o_aluop;
  logic o_alus, o_ext, o_halted;
  logic [2:0] o_st [32];

  typedef struct packed {
    int len; int pcw_n; int rw_n; int mw_n;
    logic [1:0] dst; logic [2:0] wd; logic [2:0] npc_j;
    logic alu_chk; logic [2:0] aluop; logic alus; logic ext; logic ill;
  } exp_t;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  // Expected whole-instruction behaviour, straight from the instruction table and cycle formulas.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic z, input int w);
    exp_t e;
    e = '0;
    e.pcw_n = 1;
    if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
      e.len = w + 4; e.rw_n = 1; e.dst = 2'd1; e.wd = 3'd0;
      e.alu_chk = 1'b1; e.aluop = (fn == 6'h23) ? 3'd1 : 3'd0;
    end else if (op == 6'h00 && fn == 6'h08) begin
      e.len = w + 2; e.pcw_n = 2; e.npc_j = 3'd3;
    end else if (op == 6'h0d) begin
      e.len = w + 4; e.rw_n = 1; e.alu_chk = 1'b1; e.aluop = 3'd2; e.alus = 1'b1;
    end else if (op == 6'h0f) begin
      e.len = w + 4; e.rw_n = 1; e.wd = 3'd3; e.alu_chk = 1'b1;
    end else if (op == 6'h23) begin
      e.len = 2 * w + 5; e.rw_n = 1; e.wd = 3'd1; e.alu_chk = 1'b1; e.alus = 1'b1; e.ext = 1'b1;
    end else if (op == 6'h2b) begin
      e.len = 2 * w + 4; e.mw_n = 1; e.alu_chk = 1'b1; e.alus = 1'b1; e.ext = 1'b1;
    end else if (op == 6'h04) begin
      e.len = w + 3; e.pcw_n = z ? 2 : 1; e.npc_j = z ? 3'd1 : 3'd0;
      e.alu_chk = 1'b1; e.aluop = 3'd1; e.ext = 1'b1;
    end else if (op == 6'h03) begin
      e.len = w + 2; e.pcw_n = 2; e.npc_j = 3'd2; e.rw_n = 1; e.dst = 2'd2; e.wd = 3'd2;
    end else begin
      e.len = w + 2; e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic do_reset(input int k);
    @(posedge clk); #1 rst[k] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn, input logic z);
    int w = wait_of(k);
    o_len = 0; o_irw_n = 0; o_irw_at = -1; o_pcw_n = 0; o_rw_n = 0; o_rw_at = -1;
    o_mw_n = 0; o_mw_at = -1; o_ret_n = 0; o_dst = '0; o_wd = '0; o_npc_j = '0;
    o_aluop = '0; o_alus = 1'b0; o_ext = 1'b0; o_halted = 1'b0;
    @(posedge clk); #1;
    rst[k] = 1'b0; opc[k] = op; fnc[k] = fn; zr[k] = z;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c < 32) o_st[c] = st[k];
      if (irw[k]) begin o_irw_n++; o_irw_at = c; end
      if (pcw[k]) begin o_pcw_n++; if (!irw[k]) o_npc_j = npc[k]; end
      if (rw[k]) begin o_rw_n++; o_rw_at = c; o_dst = dst[k]; o_wd = wd[k]; end
      if (mw[k]) begin o_mw_n++; o_mw_at = c; end
      if (c == w + 2) begin o_aluop = aluop[k]; o_alus = alus[k]; o_ext = ext[k]; end
      if (ret[k]) o_ret_n++;
      if (ret[k] || st[k] == 3'd5) begin
        o_len = c + 1; o_halted = (st[k] == 3'd5);
        return;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL run_timeout k=%0d op=%h fn=%h: got no retire in 64 cycles, required a retire", k, op, fn);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin rst[k] = 1'b1; opc[k] = 6'h03; fnc[k] = 6'h00; zr[k] = 1'b0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (st[k] !== 3'd0) begin n_bad++; $display("FAIL reset_state k=%0d got %0d want 0", k, st[k]); end
      n_cmp++; if ({irw[k], pcw[k], rw[k], mw[k], ret[k]} !== 5'b0) begin
        n_bad++; $display("FAIL reset_enables k=%0d got %b want 00000", k, {irw[k], pcw[k], rw[k], mw[k], ret[k]}); end
      n_cmp++; if (ill[k] !== 1'b0) begin n_bad++; $display("FAIL reset_illegal k=%0d got %b want 0", k, ill[k]); end
    end
  endtask

  task automatic test_addu();
    int exp_st [4] = '{0, 1, 2, 4};
    do_reset(0);
    run_instr(0, 6'h00, 6'h21, 1'b0);
    n_cmp++; if (o_len !== 4) begin n_bad++; $display("FAIL addu_len got %0d want 4", o_len); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (o_st[i] !== 3'(exp_st[i])) begin n_bad++; $display("FAIL addu_state[%0d] got %0d want %0d", i, o_st[i], exp_st[i]); end
    end
    n_cmp++; if (o_rw_n !== 1 || o_rw_at !== 3 || o_dst !== 2'd1 || o_wd !== 3'd0) begin
      n_bad++; $display("FAIL addu_wb got n=%0d at=%0d dst=%0d wd=%0d want n=1 at=3 dst=1 wd=0", o_rw_n, o_rw_at, o_dst, o_wd); end
  endtask

  task automatic test_lw_wait();
    int exp_st [9] = '{0, 0, 0, 1, 2, 3, 3, 3, 4};
    do_reset(1);
    run_instr(1, 6'h23, 6'h00, 1'b0);
    n_cmp++; if (o_len !== 9 || o_ret_n !== 1) begin n_bad++; $display("FAIL lw_len got len=%0d ret=%0d want 9/1", o_len, o_ret_n); end
    n_cmp++; if (o_irw_n !== 1 || o_irw_at !== 2) begin n_bad++; $display("FAIL lw_irwrite got n=%0d at=%0d want 1 at 2", o_irw_n, o_irw_at); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (o_st[i] !== 3'(exp_st[i])) begin n_bad++; $display("FAIL lw_state[%0d] got %0d want %0d", i, o_st[i], exp_st[i]); end
    end
    n_cmp++; if (o_rw_n !== 1 || o_wd !== 3'd1 || o_dst !== 2'd0) begin
      n_bad++; $display("FAIL lw_wb got n=%0d wd=%0d dst=%0d want 1/1/0", o_rw_n, o_wd, o_dst); end
  endtask

  task automatic test_beq();
    do_reset(0);
    run_instr(0, 6'h04, 6'h00, 1'b1);
    n_cmp++; if (o_len !== 3 || o_pcw_n !== 2 || o_npc_j !== 3'd1) begin
      n_bad++; $display("FAIL beq_taken got len=%0d pcw=%0d npc=%0d want 3/2/1", o_len, o_pcw_n, o_npc_j); end
    run_instr(0, 6'h04, 6'h00, 1'b0);
    n_cmp++; if (o_len !== 3 || o_pcw_n !== 1) begin
      n_bad++; $display("FAIL beq_not_taken got len=%0d pcw=%0d want 3/1", o_len, o_pcw_n); end
  endtask

  task automatic test_jal_jr();
    run_instr(0, 6'h03, 6'h00, 1'b0);
    n_cmp++; if (o_len !== 2 || o_rw_n !== 1 || o_dst !== 2'd2 || o_wd !== 3'd2 || o_npc_j !== 3'd2) begin
      n_bad++; $display("FAIL jal got len=%0d rw=%0d dst=%0d wd=%0d npc=%0d want 2/1/2/2/2", o_len, o_rw_n, o_dst, o_wd, o_npc_j); end
    run_instr(0, 6'h00, 6'h08, 1'b0);
    n_cmp++; if (o_len !== 2 || o_rw_n !== 0 || o_npc_j !== 3'd3) begin
      n_bad++; $display("FAIL jr got len=%0d rw=%0d npc=%0d want 2/0/3", o_len, o_rw_n, o_npc_j); end
  endtask

  task automatic test_illegal();
    do_reset(0);
    run_instr(0, 6'h3f, 6'h00, 1'b0);
    n_cmp++; if (o_len !== 2 || o_ret_n !== 1 || o_rw_n !== 0 || o_mw_n !== 0 || o_pcw_n !== 1) begin
      n_bad++; $display("FAIL ill_nop got len=%0d ret=%0d rw=%0d mw=%0d pcw=%0d want 2/1/0/0/1", o_len, o_ret_n, o_rw_n, o_mw_n, o_pcw_n); end
    run_instr(0, 6'h00, 6'h21, 1'b0);
    n_cmp++; if (o_len !== 4 || ill[0] !== 1'b1) begin
      n_bad++; $display("FAIL ill_next_fetch got len=%0d illegal=%b want 4/1", o_len, ill[0]); end
    do_reset(1);
    run_instr(1, 6'h3f, 6'h00, 1'b0);
    n_cmp++; if (o_halted !== 1'b1 || o_ret_n !== 0 || o_len !== 5) begin
      n_bad++; $display("FAIL trap_enter got halted=%b ret=%0d len=%0d want 1/0/5", o_halted, o_ret_n, o_len); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if (st[1] !== 3'd5 || ill[1] !== 1'b1 || {irw[1], pcw[1], rw[1], mw[1], ret[1]} !== 5'b0) begin
        n_bad++; $display("FAIL trap_hold cyc=%0d got st=%0d ill=%b en=%b want 5/1/00000", i, st[1], ill[1], {irw[1], pcw[1], rw[1], mw[1], ret[1]}); end
    end
    do_reset(1);
    @(negedge clk);
    n_cmp++; if (st[1] !== 3'd0 || ill[1] !== 1'b0) begin
      n_bad++; $display("FAIL trap_reset got st=%0d ill=%b want 0/0", st[1], ill[1]); end
    run_instr(1, 6'h00, 6'h21, 1'b0);
    n_cmp++; if (o_len !== 6) begin n_bad++; $display("FAIL trap_recover got len=%0d want 6", o_len); end
  endtask

  task automatic test_sw_reset();
    int mem_n = 0;
    bit mw_seen = 1'b0;
    do_reset(2);
    @(posedge clk); #1;
    rst[2] = 1'b0; opc[2] = 6'h2b; fnc[2] = 6'h00;
    for (int c = 0; c < 40 && mem_n < 2; c++) begin
      @(negedge clk);
      if (mw[2]) mw_seen = 1'b1;
      if (st[2] == 3'd3) mem_n++;
    end
    n_cmp++; if (mem_n !== 2) begin n_bad++; $display("FAIL sw_reach_mem got %0d MEM cycles want 2", mem_n); end
    @(posedge clk); #1 rst[2] = 1'b1;
    @(negedge clk);
    if (mw[2]) mw_seen = 1'b1;
    n_cmp++; if (st[2] !== 3'd3 || mw[2] !== 1'b0) begin
      n_bad++; $display("FAIL sw_reset_cycle got st=%0d mw=%b want 3/0", st[2], mw[2]); end
    @(posedge clk); #1 rst[2] = 1'b0;
    @(negedge clk);
    n_cmp++; if (st[2] !== 3'd0 || ill[2] !== 1'b0 || mw_seen !== 1'b0) begin
      n_bad++; $display("FAIL sw_abort got st=%0d ill=%b mw_seen=%b want 0/0/0", st[2], ill[2], mw_seen); end
  endtask

  task automatic test_random();
    int ks [3] = '{0, 2, 1};
    for (int j = 0; j < 3; j++) begin
      int k = ks[j];
      int w = wait_of(k);
      bit exp_ill = 1'b0;
      do_reset(k);
      for (int n = 0; n < 25; n++) begin
        int r = (k == 1) ? $urandom_range(0, 8) : $urandom_range(0, 11);
        logic [5:0] op, fn;
        logic z;
        exp_t e;
        fn = 6'($urandom_range(0, 63));
        z  = 1'($urandom_range(0, 1));
        case (r)
          0: begin op = 6'h00; fn = 6'h21; end
          1: begin op = 6'h00; fn = 6'h23; end
          2: begin op = 6'h00; fn = 6'h08; end
          3: op = 6'h0d;
          4: op = 6'h0f;
          5: op = 6'h23;
          6: op = 6'h2b;
          7: op = 6'h04;
          8: op = 6'h03;
          9: begin op = 6'h00; fn = 6'h00; end
          10: op = 6'h00;
          default: op = 6'($urandom_range(0, 63));
        endcase
        if (k == 1 && model(op, fn, z, w).ill) op = 6'h0f;
        e = model(op, fn, z, w);
        if (e.ill) exp_ill = 1'b1;
        run_instr(k, op, fn, z);
        n_cmp++; if (o_len !== e.len || o_ret_n !== 1) begin
          n_bad++; $display("FAIL rnd_len k=%0d op=%h fn=%h got len=%0d ret=%0d want %0d/1", k, op, fn, o_len, o_ret_n, e.len); end
        n_cmp++; if (o_irw_n !== 1 || o_irw_at !== w) begin
          n_bad++; $display("FAIL rnd_irw k=%0d op=%h got n=%0d at=%0d want 1 at %0d", k, op, o_irw_n, o_irw_at, w); end
        n_cmp++; if (o_pcw_n !== e.pcw_n || o_npc_j !== e.npc_j) begin
          n_bad++; $display("FAIL rnd_pc k=%0d op=%h z=%b got pcw=%0d npc=%0d want %0d/%0d", k, op, z, o_pcw_n, o_npc_j, e.pcw_n, e.npc_j); end
        n_cmp++; if (o_rw_n !== e.rw_n || (e.rw_n == 1 && (o_dst !== e.dst || o_wd !== e.wd))) begin
          n_bad++; $display("FAIL rnd_wb k=%0d op=%h fn=%h got n=%0d dst=%0d wd=%0d want %0d/%0d/%0d", k, op, fn, o_rw_n, o_dst, o_wd, e.rw_n, e.dst, e.wd); end
        n_cmp++; if (o_mw_n !== e.mw_n || (e.mw_n == 1 && o_mw_at !== e.len - 1)) begin
          n_bad++; $display("FAIL rnd_mem k=%0d op=%h got n=%0d at=%0d want %0d at %0d", k, op, o_mw_n, o_mw_at, e.mw_n, e.len - 1); end
        if (e.alu_chk) begin
          n_cmp++; if (o_aluop !== e.aluop || o_alus !== e.alus || o_ext !== e.ext) begin
            n_bad++; $display("FAIL rnd_alu k=%0d op=%h got op=%0d s=%b ext=%b want %0d/%b/%b", k, op, o_aluop, o_alus, o_ext, e.aluop, e.alus, e.ext); end
        end
      end
      @(negedge clk);
      n_cmp++; if (ill[k] !== exp_ill) begin n_bad++; $display("FAIL rnd_sticky k=%0d got %b want %b", k, ill[k], exp_ill); end
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jal_jr();
    test_illegal();
    test_sw_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- A registered FSM sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Emits per-state datapath enables for a shared-ALU, single-memory-port datapath.
- Adds configurable memory wait states, an illegal-instruction mode and a retire pulse.
- Instruction set: addu, subu, ori, lw, sw, beq, lui, jal, jr.

Parameters:
- MEM_WAIT, 0: extra wait cycles on each memory access (fetch and lw/sw). Range 0..15.
- ILLEGAL_TRAP, 0: 0 = illegal instruction retires as a nop; 1 = FSM enters HALT until reset.
- CNT_W, localparam = max(1, clog2(MEM_WAIT+1)): width of the wait counter.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- opcode, input, 6: IR[31:26]; valid from DECODE onward.
- func, input, 6: IR[5:0].
- zero, input, 1: ALU equal flag, sampled in EXEC for beq.
- IRWrite, output, 1: load instruction register.
- PCWrite, output, 1: PC load enable.
- NPC_sel, output, 3: ADD4 / BEQ / JAL / REG.
- RegWrite, output, 1: GRF write enable.
- RegDst, output, 2: write address select; 0 rt, 1 rd, 2 $31.
- WD_sel, output, 3: write data select; 0 ALU, 1 MEM, 2 PC, 3 LUI.
- ExtOp, output, 1: 1 = sign-extend immediate.
- ALU_s, output, 1: 1 = ALU B operand is the immediate.
- ALUOP, output, 3: ADD / SUB / OR.
- MemWrite, output, 1: DM write strobe.
- retire, output, 1: one-cycle pulse on the last cycle of each instruction.
- illegal, output, 1: sticky; set on any undecoded instruction.
- state, output, 3: current FSM state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. State and wait counter are registered.
- All enables are combinational from state, opcode and func. In a reset cycle every enable is forced to 0.
- Reset: state=FETCH, wait counter=0, illegal=0. The next cycle starts a fetch. Reset in any state (including MEM with sw pending) aborts with no write.
- Wait counter: cleared on entry to FETCH and MEM, increments each cycle in those states. The access completes when the counter == MEM_WAIT, so a memory state lasts MEM_WAIT+1 cycles.
- FETCH, on completion:
  - IRWrite=1, PCWrite=1, NPC_sel=ADD4.
  - Go to DECODE.
- DECODE:
  - jal: PCWrite=1, NPC_sel=JAL, RegWrite=1, RegDst=2, WD_sel=PC (PC already holds PC+4). retire=1; go to FETCH.
  - jr: PCWrite=1, NPC_sel=REG, retire=1; go to FETCH.
  - Illegal with ILLEGAL_TRAP=0: retire=1, illegal<=1, no writes; go to FETCH.
  - Illegal with ILLEGAL_TRAP=1: illegal<=1; go to HALT.
  - Otherwise go to EXEC.
- Illegal means any opcode/func pair outside the set. An opcode-0 instruction with an unknown func is illegal; sll $0,$0,0 (nop) is illegal too.
- EXEC:
  - addu: ALUOP=ADD, ALU_s=0; go to WB.
  - subu: ALUOP=SUB, ALU_s=0; go to WB.
  - ori: ALUOP=OR, ALU_s=1, ExtOp=0; go to WB.
  - lui: go to WB.
  - lw/sw: ALUOP=ADD, ALU_s=1, ExtOp=1; go to MEM.
  - beq: ALUOP=SUB, ExtOp=1, NPC_sel=BEQ, PCWrite=zero, retire=1; go to FETCH.
- MEM:
  - sw: MemWrite=1 only in the completion cycle, then retire=1 and go to FETCH.
  - lw: go to WB on completion.
  - MemWrite is never asserted on a non-final wait cycle.
- WB:
  - RegWrite=1.
  - addu/subu: RegDst=1, WD_sel=ALU.
  - ori: RegDst=0, WD_sel=ALU.
  - lui: RegDst=0, WD_sel=LUI.
  - lw: RegDst=0, WD_sel=MEM.
  - retire=1; go to FETCH.
- HALT: all enables 0; leave only on reset.
- Defaults whenever not stated: all enables 0, NPC_sel=ADD4, ALUOP=ADD, RegDst=0, WD_sel=0, ExtOp=0, ALU_s=0.
- Cycle counts with W=MEM_WAIT:
  - jal, jr: W+2.
  - beq: W+3.
  - addu, subu, ori, lui: W+4.
  - sw: 2W+4.
  - lw: 2W+5.

Decomposition:
- Shared package mc_defs:
  - opcode/func constants.
  - ALUOP codes ADD=0, SUB=1, OR=2 (shared with ALU).
  - NPC_sel codes ADD4=0, BEQ=1, JAL=2, REG=3 (shared with NPC).
  - WD_sel codes.
  - state encodings.
- Sub-module mc_decode: purely combinational opcode/func to one-hot instruction class plus the illegal flag. The FSM and enable generation stay in mc_controller.

Test Plan:
- MEM_WAIT=0, reset then addu: states 0,1,2,4. RegWrite=1, RegDst=1, WD_sel=0 only in the WB cycle; retire after 4 cycles.
- MEM_WAIT=2, lw: FETCH holds 3 cycles with IRWrite only in the 3rd. MEM holds 3 cycles. WB RegWrite with WD_sel=1. Total 9 cycles, one retire.
- beq with zero=1, then zero=0: PCWrite=1, NPC_sel=1 in EXEC for the first; PCWrite=0 for the second. Both retire after 3 cycles.
- jal then jr: each 2 cycles. jal DECODE shows RegDst=2, WD_sel=2, NPC_sel=2, RegWrite=1. jr DECODE shows NPC_sel=3.
- opcode 6'b111111 with ILLEGAL_TRAP=0: illegal rises, retire pulses, no enables, next fetch follows. With ILLEGAL_TRAP=1: state=5 holds, enables stay 0 until reset.
- MEM_WAIT=3, sw with reset asserted on the 3rd MEM cycle: MemWrite never 1, state=0 the next cycle, illegal=0.
